// File: rtl/alu_seq.sv
// Sequential execute unit: single-cycle RV32I ALU ops plus iterative RV32M mul/div.
// Latency: simple ops and short-circuited divides 1 edge; MUL*/DIV*/REM* DATA_WIDTH+1 edges.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, flush kills any op.

package alu_pkg;
  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLL    = 5'd2,
    SLT    = 5'd3,
    SLTU   = 5'd4,
    XOR    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    OR     = 5'd8,
    AND    = 5'd9,
    MUL    = 5'd10,
    MULH   = 5'd11,
    MULHSU = 5'd12,
    MULHU  = 5'd13,
    DIV    = 5'd14,
    DIVU   = 5'd15,
    REM    = 5'd16,
    REMU   = 5'd17
  } aluop_t;
endpackage

module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  aluop_t                op,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] opr_result,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   result_q, result_d;
  // {hi, lo}: multiply = {partial product, remaining multiplier};
  // divide = {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;   // |a| for multiply, |divisor| for divide
  logic [SW-1:0]  cnt_q, cnt_d;
  aluop_t         op_q, op_d;
  logic           neg_q, neg_d;     // product / quotient sign
  logic           rneg_q, rneg_d;   // remainder sign (follows dividend)

  // Decode of the incoming op
  logic           a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic           is_iter, is_div, is_rem, is_sdiv;
  logic           b_zero, sovf;
  logic [SW-1:0]  shamt;
  logic signed [W-1:0] a_signed;
  logic [W-1:0]   simple_res;

  // Iteration datapath (driven by the stored op)
  logic           is_div_q;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift, div_trial;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, iter_res;

  assign shamt    = opr_b[SW-1:0];
  assign a_signed = opr_a;

  // Operand classification, magnitudes and short-circuit detection for M ops
  always_comb begin
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
    is_iter = 1'b0;
    is_div  = 1'b0;
    is_rem  = 1'b0;
    is_sdiv = 1'b0;
    case (op)
      MUL, MULH: begin a_sgn = 1'b1; b_sgn = 1'b1; is_iter = 1'b1; end
      MULHSU:    begin a_sgn = 1'b1; is_iter = 1'b1; end
      MULHU:     begin is_iter = 1'b1; end
      DIV:       begin a_sgn = 1'b1; b_sgn = 1'b1; is_iter = 1'b1; is_div = 1'b1; is_sdiv = 1'b1; end
      DIVU:      begin is_iter = 1'b1; is_div = 1'b1; end
      REM:       begin a_sgn = 1'b1; b_sgn = 1'b1; is_iter = 1'b1; is_div = 1'b1; is_rem = 1'b1; is_sdiv = 1'b1; end
      REMU:      begin is_iter = 1'b1; is_div = 1'b1; is_rem = 1'b1; end
      default:   begin end
    endcase
    a_neg  = a_sgn & opr_a[W-1];
    b_neg  = b_sgn & opr_b[W-1];
    a_mag  = a_neg ? (~opr_a + 1'b1) : opr_a;
    b_mag  = b_neg ? (~opr_b + 1'b1) : opr_b;
    b_zero = (opr_b == '0);
    sovf   = is_sdiv && (opr_a == {1'b1, {(W-1){1'b0}}}) && (opr_b == '1);
  end

  // Single-cycle integer ops; unknown encodings produce zero
  always_comb begin
    simple_res = '0;
    case (op)
      ADD:     simple_res = opr_a + opr_b;
      SUB:     simple_res = opr_a - opr_b;
      SLL:     simple_res = opr_a << shamt;
      SLT:     simple_res = {{(W-1){1'b0}}, ($signed(opr_a) < $signed(opr_b))};
      SLTU:    simple_res = {{(W-1){1'b0}}, (opr_a < opr_b)};
      XOR:     simple_res = opr_a ^ opr_b;
      SRL:     simple_res = opr_a >> shamt;
      SRA:     simple_res = a_signed >>> shamt;
      OR:      simple_res = opr_a | opr_b;
      AND:     simple_res = opr_a & opr_b;
      default: simple_res = '0;
    endcase
  end

  // One shift-add or restoring-divide step, plus the sign-corrected final result
  always_comb begin
    is_div_q  = (op_q == DIV) || (op_q == DIVU) || (op_q == REM) || (op_q == REMU);
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    acc_step  = '0;
    if (is_div_q) begin
      if (!div_trial[W]) begin
        acc_step = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end
    prod = neg_q ? (~acc_step + 1'b1) : acc_step;
    quo  = neg_q ? (~acc_step[W-1:0] + 1'b1) : acc_step[W-1:0];
    rem  = rneg_q ? (~acc_step[2*W-1:W] + 1'b1) : acc_step[2*W-1:W];
    case (op_q)
      MUL:                 iter_res = prod[W-1:0];
      MULH, MULHSU, MULHU: iter_res = prod[2*W-1:W];
      DIV, DIVU:           iter_res = quo;
      default:             iter_res = rem;
    endcase
  end

  // FSM next-state and datapath register updates; flush overrides everything
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_iter) begin
            result_d = simple_res;
            state_d  = S_DONE;
          end else if (is_div && b_zero) begin
            result_d = is_rem ? opr_a : '1;
            state_d  = S_DONE;
          end else if (sovf) begin
            result_d = is_rem ? '0 : opr_a;
            state_d  = S_DONE;
          end else begin
            acc_d   = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_d  = is_div ? b_mag : a_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            op_d    = op;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(W - 1)) begin
          result_d = iter_res;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_q     <= ADD;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_BUSY);
  assign opr_result = result_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table of directed ops with expected result/latency,
// plus hand-written backpressure, flush and mid-op reset sequences.
// Inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  aluop_t      op;
  logic [31:0] opr_a, opr_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] opr_result;
  logic        busy;

  int errors = 0;
  int checks = 0;

  alu_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .opr_a(opr_a), .opr_b(opr_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .opr_result(opr_result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    aluop_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure edges until out_valid, check result/latency/busy, then consume it
  task automatic run_op(input string name, input aluop_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_cnt;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    opr_a    = a;
    opr_b    = b;
    tick();
    in_valid = 1'b0;
    opr_a    = 32'hDEAD_BEEF;
    opr_b    = 32'hDEAD_BEEF;
    lat      = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_result"}, opr_result, exp);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int n;
    vecs[0]  = '{ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    vecs[1]  = '{SUB,    32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1};
    vecs[2]  = '{SRA,    32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1};
    vecs[3]  = '{SRL,    32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1};
    vecs[4]  = '{SLL,    32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1};
    vecs[5]  = '{SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[6]  = '{SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[7]  = '{XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1};
    vecs[8]  = '{OR,     32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1};
    vecs[9]  = '{AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1};
    vecs[10] = '{MUL,    32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 33};
    vecs[11] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[12] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[13] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[14] = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[15] = '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[16] = '{DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[17] = '{REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[18] = '{DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
    vecs[19] = '{REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
    vecs[20] = '{DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[21] = '{REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1};
    vecs[22] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[23] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[24] = '{DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[25] = '{aluop_t'(5'd31), 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = ADD;
    opr_a     = '0;
    opr_b     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    chk("reset_result", opr_result, 32'h0);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 26; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result held while out_ready low; inputs in DONE ignored
    in_valid = 1'b1; op = ADD; opr_a = 32'd1; opr_b = 32'd2;
    tick();
    op = SUB; opr_a = 32'd100; opr_b = 32'd1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_result_c%0d", c), opr_result, 32'd3);
      chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
    chk("bp_release_result", opr_result, 32'd3);

    // Flush beats a same-cycle accept
    in_valid = 1'b1; flush = 1'b1; op = MUL; opr_a = 32'd3; opr_b = 32'd3;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Flush at cycle 10 of a DIVU: result never appears
    in_valid = 1'b1; op = DIVU; opr_a = 32'd1000; opr_b = 32'd3;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_next", {29'd0, in_ready, out_valid, busy}, 32'b100);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) n++;
      tick();
    end
    chk("flush_no_valid", 32'(n), 32'd0);
    run_op("post_flush_add", ADD, 32'd4, 32'd5, 32'd9, 1);

    // Reset mid-MUL
    in_valid = 1'b1; op = MUL; opr_a = 32'h1234; opr_b = 32'h5678;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    chk("midrst_result", opr_result, 32'h0);
    rst_n = 1'b1;
    tick();
    run_op("post_rst_mul", MUL, 32'd6, 32'd7, 32'd42, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
